uart_io_ctrl: RTL and testbench
===============================

Name: uart_io_ctrl

Overview:
- Owns the single UART receiver/sender pair and shares it between two requesters:
  - the instruction loader, in load mode;
  - the CPU core's IN/OUT instructions, in run mode.
- Buffers received bytes in a small FIFO.
- Assembles 4 bytes MSB-first into 32-bit words, for CPU IN and for loader words.
- Serializes 32-bit OUT words into 4 bytes MSB-first with the sender handshake.
- Sits between receiver/sender and the core/inst_memory in the top level.

Parameters:
- RX_DEPTH, 4, receive FIFO depth in bytes (power of two, ≥2).
- ADDR_WIDTH, 2, width of the loader word address counter.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from receiver.
- rx_valid  in  1  one-cycle pulse: rx_data is valid.
- tx_data  out  8  byte to sender.
- tx_enable  out  1  one-cycle pulse: start sending tx_data.
- tx_ready  in  1  sender idle; drops the cycle after an accepted tx_enable and stays low while busy.
- load_mode  in  1  1 = bytes go to loader; 0 = bytes serve CPU IN.
- loader_word  out  32  assembled instruction word.
- loader_addr  out  ADDR_WIDTH  word index for loader_word.
- loader_we  out  1  one-cycle write strobe for loader_word at loader_addr.
- io_req  in  1  CPU request, held high until io_done.
- io_we  in  1  1 = OUT, 0 = IN; sampled with io_req.
- io_wdata  in  32  OUT word; sampled when the request is accepted.
- io_rdata  out  32  IN result; valid when io_done.
- io_done  out  1  one-cycle completion pulse.
- rx_overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1):
  - all outputs 0; FSM to IDLE; FIFO flushed; byte index and loader_addr cleared.
  - Takes priority over everything, including mid-op; tx_enable is never left high.
- RX FIFO:
  - Pushes on rx_valid; show-ahead head; a pop takes effect next cycle.
  - Push while full with no pop: byte dropped, rx_overflow set.
  - Push and pop in the same cycle while full: both occur, no overflow.
- FSM states: IDLE, LOAD, IN_COLLECT, OUT_ISSUE, OUT_WAIT_BUSY, OUT_WAIT_READY, DONE.
- IDLE:
  - load_mode=1 → LOAD.
  - io_req & !io_we → IN_COLLECT (idx=0).
  - io_req & io_we → latch io_wdata, idx=0, → OUT_ISSUE.
  - load_mode has priority; io_req stays pending during LOAD.
- LOAD:
  - Each FIFO byte is popped into shift register bits [31-8*idx -: 8].
  - At idx=3: loader_we=1 for one cycle with the full word; loader_addr increments the next cycle; ADDR_WIDTH wrap-around is allowed.
  - load_mode 0→1 edge clears idx and loader_addr.
  - load_mode=0 → IDLE; any partial word is discarded.
- IN_COLLECT:
  - Pops one byte per cycle when the FIFO is non-empty, MSB first.
  - After the 4th pop → DONE.
  - io_rdata updates only at completion.
- OUT_ISSUE:
  - Waits for tx_ready=1.
  - Then drives tx_data = word[31-8*idx -: 8] and tx_enable=1 for exactly one cycle → OUT_WAIT_BUSY.
- OUT_WAIT_BUSY: one cycle, ignores tx_ready → OUT_WAIT_READY.
- OUT_WAIT_READY:
  - On tx_ready=1: if idx=3 → DONE, else idx+1 → OUT_ISSUE.
- DONE: io_done=1 for one cycle → IDLE. io_req must drop after io_done; a re-request is taken no earlier than the next IDLE cycle.
- load_mode changes during a CPU op: the op completes first; the mode is honoured in IDLE.
- Bytes arriving during OUT are buffered in the FIFO, subject to overflow rules.
- Latency:
  - IN: io_done 1 cycle after the 4th byte is popped; minimum 5 cycles from acceptance when the FIFO holds 4 bytes.
  - OUT: io_done 1 cycle after the sender is ready following the 4th byte.

Decomposition:
- Package uart_io_pkg:
  - FSM state enum;
  - constants BYTES_PER_WORD=4 and BYTE_W=8;
  - opcode localparams OP_IN=6'b111011 and OP_OUT=6'b111100, shared with the core.
- One sub-module, uart_rx_fifo:
  - params DEPTH, WIDTH=8;
  - ports push, push_data, pop, head, empty, full, overflow.

Test Plan:
- Reset mid-OUT (after the 2nd tx_enable) → no further tx_enable; all outputs 0; FIFO empty; next OUT restarts at byte 0.
- load_mode=1, push bytes 00 00 00 EC, then 00 00 00 F0 → loader_we twice:
  - word 0x000000EC at addr 0;
  - word 0x000000F0 at addr 1.
- load_mode=0, IN request, push 12 34 56 78 with arbitrary gaps → io_done once; io_rdata=0x12345678.
- OUT io_wdata=0xDEADBEEF with a sender model busy 10 cycles per byte:
  - tx_enable pulses carry DE, AD, BE, EF, each only while tx_ready=1;
  - io_done follows the final ready.
- With RX_DEPTH=4 and no consumer, push 5 bytes → rx_overflow=1; FIFO holds the first 4. Push and pop in the same cycle while full → no overflow.
- io_req IN with load_mode=1 → request stalls; drop load_mode mid-word → partial word discarded; the IN then completes from subsequent bytes.

Source files
------------

// File: rtl/uart_io_pkg.sv
// Shared types and constants for the UART I/O controller and the core's IN/OUT opcodes.
package uart_io_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    localparam logic [5:0] OP_IN  = 6'b111011;
    localparam logic [5:0] OP_OUT = 6'b111100;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        IN_COLLECT,
        OUT_ISSUE,
        OUT_WAIT_BUSY,
        OUT_WAIT_READY,
        DONE
    } state_t;

    // Byte lanes are numbered MSB-first: idx 0 is bits [31:24].
    function automatic logic [BYTE_W-1:0] get_byte(input logic [WORD_W-1:0] word,
                                                   input logic [1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] word,
                                                   input logic [1:0] idx,
                                                   input logic [BYTE_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = word;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive byte FIFO with a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// Shares one UART receiver/sender pair between the instruction loader and CPU IN/OUT.
//
// state          | meaning
// IDLE           | waiting for load_mode or a CPU request
// LOAD           | packing FIFO bytes into loader words
// IN_COLLECT     | popping 4 bytes for a CPU IN
// OUT_ISSUE      | waiting for sender ready, then pulsing tx_enable
// OUT_WAIT_BUSY  | enable cycle; sender ready not yet meaningful
// OUT_WAIT_READY | waiting for the sender to finish the byte
// DONE           | io_done pulse
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int RX_DEPTH   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_enable,
    input  logic                  tx_ready,
    input  logic                  load_mode,
    output logic [31:0]           loader_word,
    output logic [ADDR_WIDTH-1:0] loader_addr,
    output logic                  loader_we,
    input  logic                  io_req,
    input  logic                  io_we,
    input  logic [31:0]           io_wdata,
    output logic [31:0]           io_rdata,
    output logic                  io_done,
    output logic                  rx_overflow
);
    state_t      state;
    logic [1:0]  idx;
    logic [31:0] word_sr;

    logic        fifo_pop;
    logic [7:0]  fifo_head;
    logic        fifo_empty;
    logic        unused_fifo_full;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .CLK       (CLK),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (unused_fifo_full),
        .overflow  (rx_overflow)
    );

    // Bytes are left in the FIFO the moment load_mode drops so a pending IN can use them.
    assign fifo_pop = !fifo_empty &&
                      (((state == LOAD) && load_mode) || (state == IN_COLLECT));

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            word_sr     <= '0;
            tx_data     <= '0;
            tx_enable   <= 1'b0;
            loader_word <= '0;
            loader_addr <= '0;
            loader_we   <= 1'b0;
            io_rdata    <= '0;
            io_done     <= 1'b0;
        end else begin
            tx_enable <= 1'b0;
            loader_we <= 1'b0;
            io_done   <= 1'b0;
            if (loader_we) begin
                loader_addr <= loader_addr + ADDR_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    idx <= '0;
                    if (load_mode) begin
                        // Entering LOAD from IDLE is always a fresh load session.
                        loader_addr <= '0;
                        state       <= LOAD;
                    end else if (io_req) begin
                        if (io_we) begin
                            word_sr <= io_wdata;
                            state   <= OUT_ISSUE;
                        end else begin
                            state <= IN_COLLECT;
                        end
                    end
                end

                LOAD: begin
                    if (!load_mode) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else if (!fifo_empty) begin
                        word_sr <= put_byte(word_sr, idx, fifo_head);
                        idx     <= idx + 2'd1;
                        if (idx == LAST_IDX) begin
                            loader_word <= put_byte(word_sr, idx, fifo_head);
                            loader_we   <= 1'b1;
                        end
                    end
                end

                IN_COLLECT: begin
                    if (!fifo_empty) begin
                        word_sr <= put_byte(word_sr, idx, fifo_head);
                        idx     <= idx + 2'd1;
                        if (idx == LAST_IDX) begin
                            io_rdata <= put_byte(word_sr, idx, fifo_head);
                            io_done  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end

                OUT_ISSUE: begin
                    if (tx_ready) begin
                        tx_data   <= get_byte(word_sr, idx);
                        tx_enable <= 1'b1;
                        state     <= OUT_WAIT_BUSY;
                    end
                end

                OUT_WAIT_BUSY: begin
                    state <= OUT_WAIT_READY;
                end

                OUT_WAIT_READY: begin
                    if (tx_ready) begin
                        if (idx == LAST_IDX) begin
                            io_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= OUT_ISSUE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: loader, CPU IN/OUT, FIFO overflow and reset recovery.
module tb_uart_io_ctrl;

    logic        CLK;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_ready;
    logic        load_mode;
    logic [31:0] loader_word;
    logic [1:0]  loader_addr;
    logic        loader_we;
    logic        io_req;
    logic        io_we;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_done;
    logic        rx_overflow;

    int checks = 0;
    int errors = 0;

    int          done_cnt = 0;
    int          en_cnt   = 0;
    int          ld_cnt   = 0;
    logic [31:0] ld_word [16];
    logic [1:0]  ld_addr [16];

    uart_io_ctrl #(
        .RX_DEPTH   (4),
        .ADDR_WIDTH (2)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_ready    (tx_ready),
        .load_mode   (load_mode),
        .loader_word (loader_word),
        .loader_addr (loader_addr),
        .loader_we   (loader_we),
        .io_req      (io_req),
        .io_we       (io_we),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .io_done     (io_done),
        .rx_overflow (rx_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Event recorder, sampled mid-cycle away from the active edge.
    always @(negedge CLK) begin
        if (io_done === 1'b1) done_cnt++;
        if (tx_enable === 1'b1) en_cnt++;
        if (loader_we === 1'b1 && ld_cnt < 16) begin
            ld_word[ld_cnt] = loader_word;
            ld_addr[ld_cnt] = loader_addr;
            ld_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        io_req    = 1'b0;
        io_we     = 1'b0;
        io_wdata  = 32'h0;
        load_mode = 1'b0;
        tx_ready  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_in();
        io_we  = 1'b0;
        io_req = 1'b1;
    endtask

    task automatic wait_done(input logic [31:0] exp, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK);
            #1;
            if (io_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: got no io_done, expected a pulse", name);
        end else begin
            checks++;
            if (io_rdata !== exp) begin
                errors++;
                $display("FAIL %s_rdata: got %h expected %h", name, io_rdata, exp);
            end
        end
        io_req = 1'b0;
    endtask

    // Drives an OUT request with a sender that stays busy busy_len cycles per byte.
    // abort_after > 0 returns right after that many tx_enable pulses.
    task automatic run_out(input logic [31:0] w, input int busy_len,
                           input int abort_after, input string name);
        int         n_en;
        int         busy;
        int         last_ready_cyc;
        int         done_cyc;
        bit         pending;
        bit         finished;
        logic [7:0] exp_b;
        n_en = 0; busy = 0; pending = 0; finished = 0;
        last_ready_cyc = -10; done_cyc = -1;
        tx_ready = 1'b1;
        io_we    = 1'b1;
        io_wdata = w;
        io_req   = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge CLK);
            #1;
            if (tx_enable === 1'b1) begin
                checks++;
                if (n_en > 3) begin
                    errors++;
                    $display("FAIL %s_extra_enable: got enable %0d expected at most 4", name, n_en + 1);
                end else begin
                    exp_b = 8'(w >> (8 * (3 - n_en)));
                    if (tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL %s_byte%0d: got %h expected %h", name, n_en, tx_data, exp_b);
                    end
                end
                checks++;
                if (tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_enable_while_busy: got tx_ready %b expected 1", name, tx_ready);
                end
                n_en++;
                if (abort_after > 0 && n_en == abort_after) begin
                    finished = 1'b1;
                    break;
                end
            end
            if (io_done === 1'b1) begin
                done_cyc = cyc;
                io_req   = 1'b0;
                finished = 1'b1;
                break;
            end
            if (pending) begin
                tx_ready = 1'b0;
                busy     = busy_len;
                pending  = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    tx_ready       = 1'b1;
                    last_ready_cyc = cyc;
                end
            end
            if (tx_enable === 1'b1) pending = 1'b1;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s_timeout: got %0d enables and no io_done, expected completion", name, n_en);
        end else if (abort_after == 0) begin
            checks++;
            if (n_en != 4) begin
                errors++;
                $display("FAIL %s_enable_count: got %0d expected 4", name, n_en);
            end
            checks++;
            if (done_cyc != last_ready_cyc + 1) begin
                errors++;
                $display("FAIL %s_done_timing: got cycle %0d expected %0d", name, done_cyc, last_ready_cyc + 1);
            end
            idle(3);
            checks++;
            if (io_done !== 1'b0 || tx_enable !== 1'b0) begin
                errors++;
                $display("FAIL %s_quiet_after: got done %b enable %b expected 0 0", name, io_done, tx_enable);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (tx_data !== 8'h00 || tx_enable !== 1'b0) begin
            errors++;
            $display("FAIL %s_tx: got data %h enable %b expected 00 0", name, tx_data, tx_enable);
        end
        checks++;
        if (loader_word !== 32'h0 || loader_addr !== 2'd0 || loader_we !== 1'b0) begin
            errors++;
            $display("FAIL %s_loader: got word %h addr %0d we %b expected 0 0 0",
                     name, loader_word, loader_addr, loader_we);
        end
        checks++;
        if (io_rdata !== 32'h0 || io_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_io: got rdata %h done %b expected 0 0", name, io_rdata, io_done);
        end
        checks++;
        if (rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s_overflow: got %b expected 0", name, rx_overflow);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_outputs_zero("reset");
    endtask

    task automatic test_load();
        int base;
        logic [7:0] bytes [8];
        bytes = '{8'h00, 8'h00, 8'h00, 8'hEC, 8'h00, 8'h00, 8'h00, 8'hF0};
        base = ld_cnt;
        load_mode = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) push_byte(bytes[i]);
        idle(4);
        checks++;
        if (ld_cnt - base != 2) begin
            errors++;
            $display("FAIL load_we_count: got %0d expected 2", ld_cnt - base);
        end else begin
            checks++;
            if (ld_word[base] !== 32'h000000EC || ld_addr[base] !== 2'd0) begin
                errors++;
                $display("FAIL load_word0: got %h@%0d expected 000000ec@0", ld_word[base], ld_addr[base]);
            end
            checks++;
            if (ld_word[base+1] !== 32'h000000F0 || ld_addr[base+1] !== 2'd1) begin
                errors++;
                $display("FAIL load_word1: got %h@%0d expected 000000f0@1", ld_word[base+1], ld_addr[base+1]);
            end
        end
        checks++;
        if (loader_addr !== 2'd2) begin
            errors++;
            $display("FAIL load_addr_after: got %0d expected 2", loader_addr);
        end
        // Partial word then a fresh session: addr and byte index restart.
        push_byte(8'hAA);
        push_byte(8'hBB);
        idle(3);
        load_mode = 1'b0;
        idle(2);
        load_mode = 1'b1;
        idle(2);
        checks++;
        if (loader_addr !== 2'd0) begin
            errors++;
            $display("FAIL load_addr_restart: got %0d expected 0", loader_addr);
        end
        base = ld_cnt;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        idle(4);
        checks++;
        if (ld_cnt - base != 1 || ld_word[base] !== 32'h11223344 || ld_addr[base] !== 2'd0) begin
            errors++;
            $display("FAIL load_after_partial: got %0d writes word %h@%0d expected 1 write 11223344@0",
                     ld_cnt - base, ld_word[base], ld_addr[base]);
        end
        load_mode = 1'b0;
        idle(2);
    endtask

    task automatic test_in();
        int base;
        base = done_cnt;
        start_in();
        idle(1);
        push_byte(8'h12);
        push_byte(8'h34);
        idle(3);
        push_byte(8'h56);
        idle(2);
        checks++;
        if (io_rdata !== 32'h0 || done_cnt != base) begin
            errors++;
            $display("FAIL in_partial: got rdata %h dones %0d expected 00000000 0", io_rdata, done_cnt - base);
        end
        idle(4);
        push_byte(8'h78);
        wait_done(32'h12345678, "in");
        idle(2);
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL in_done_count: got %0d expected 1", done_cnt - base);
        end
    endtask

    task automatic test_out();
        run_out(32'hDEADBEEF, 10, 0, "out");
    endtask

    task automatic test_load_stall_in();
        int ld_base;
        int done_base;
        ld_base   = ld_cnt;
        done_base = done_cnt;
        load_mode = 1'b1;
        idle(2);
        start_in();
        push_byte(8'h55);
        push_byte(8'h66);
        idle(4);
        checks++;
        if (done_cnt != done_base) begin
            errors++;
            $display("FAIL stall_no_done: got %0d dones expected 0", done_cnt - done_base);
        end
        load_mode = 1'b0;
        push_byte(8'h9A);
        push_byte(8'hBC);
        push_byte(8'hDE);
        push_byte(8'hF0);
        wait_done(32'h9ABCDEF0, "stall_in");
        idle(2);
        checks++;
        if (ld_cnt != ld_base) begin
            errors++;
            $display("FAIL stall_partial_discard: got %0d loader writes expected 0", ld_cnt - ld_base);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push_byte(8'hB0);
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        checks++;
        if (rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_full: got %b expected 0", rx_overflow);
        end
        push_byte(8'hB4);
        checks++;
        if (rx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", rx_overflow);
        end
        start_in();
        wait_done(32'hB0B1B2B3, "ovf_in");
        idle(1);
        checks++;
        if (rx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", rx_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        push_byte(8'hC0);
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        start_in();
        idle(1);
        push_byte(8'hC4);
        checks++;
        if (rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_no_ovf: got %b expected 0", rx_overflow);
        end
        wait_done(32'hC0C1C2C3, "fullpp_in0");
        idle(1);
        start_in();
        push_byte(8'hC5);
        push_byte(8'hC6);
        push_byte(8'hC7);
        wait_done(32'hC4C5C6C7, "fullpp_in1");
        idle(1);
    endtask

    task automatic test_reset_mid_out();
        int en_base;
        push_byte(8'h77);
        push_byte(8'h88);
        run_out(32'hA1B2C3D4, 3, 2, "abort_out");
        rst      = 1'b1;
        io_req   = 1'b0;
        tx_ready = 1'b1;
        @(posedge CLK);
        #1;
        check_outputs_zero("mid_out_reset");
        @(posedge CLK);
        #1;
        rst = 1'b0;
        en_base = en_cnt;
        idle(15);
        checks++;
        if (en_cnt != en_base) begin
            errors++;
            $display("FAIL mid_out_no_enable: got %0d enables expected 0", en_cnt - en_base);
        end
        start_in();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        wait_done(32'h11223344, "after_reset_in");
        idle(1);
        run_out(32'hCAFEF00D, 2, 0, "restart_out");
    endtask

    initial begin
        test_reset();
        test_load();
        test_in();
        test_out();
        test_load_stall_in();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
